// File: rtl/afifo_rtl_pkg.sv
// Shared types and pointer-code helpers for both clock-domain halves of the async FIFO.
package afifo_rtl_pkg;

    localparam int AFIFO_PTR_MAX_W       = 32;
    localparam int AFIFO_MIN_SYNC_STAGES = 2;

    // Wide container; each side slices it down to ADDR_WIDTH+1 bits.
    typedef logic [AFIFO_PTR_MAX_W-1:0] afifo_ptr_t;

    function automatic afifo_ptr_t bin2gray(input afifo_ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic afifo_ptr_t gray2bin(input afifo_ptr_t g);
        afifo_ptr_t b;
        b = '0;
        b[AFIFO_PTR_MAX_W-1] = g[AFIFO_PTR_MAX_W-1];
        for (int i = AFIFO_PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/afifo_rd_ctrl_sync.sv
// Multi-flop synchronizer carrying a Gray pointer across the clock boundary.
module afifo_sync_ff
    import afifo_rtl_pkg::*;
#(
    parameter int WIDTH  = 9,
    parameter int STAGES = 2
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    localparam int N = (STAGES < AFIFO_MIN_SYNC_STAGES) ? AFIFO_MIN_SYNC_STAGES : STAGES;

    logic [WIDTH-1:0] r_stage [N];

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int i = 0; i < N; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < N; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_q = r_stage[N-1];

endmodule

// File: rtl/afifo_rd_ctrl.sv
// Read-side control of the async FIFO: read pointer, empty/almost-empty, level, underflow.
module afifo_rd_ctrl
    import afifo_rtl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int AE_THRESH   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  rinc,
    input  logic [ADDR_WIDTH:0]   wptr,
    output logic [ADDR_WIDTH:0]   rptr,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  ren,
    output logic                  rempty,
    output logic                  ralmost_empty,
    output logic [ADDR_WIDTH:0]   rlevel,
    output logic                  runderflow
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0] AE_T = PTR_W'(AE_THRESH);

    logic [PTR_W-1:0] r_bin;
    logic [PTR_W-1:0] r_gray;
    logic             r_empty;
    logic             r_aempty;
    logic [PTR_W-1:0] r_level;
    logic             r_uf;

    logic             w_racc;
    logic [PTR_W-1:0] w_wq_sync;
    logic [PTR_W-1:0] w_bin_next;
    logic [PTR_W-1:0] w_gray_next;
    logic [PTR_W-1:0] w_wbin_sync;
    logic [PTR_W-1:0] w_level_next;

    afifo_sync_ff #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .i_d    (wptr),
        .o_q    (w_wq_sync)
    );

    assign w_racc       = rinc & ~r_empty;
    assign w_bin_next   = r_bin + PTR_W'(w_racc);
    assign w_gray_next  = PTR_W'(bin2gray(afifo_ptr_t'(w_bin_next)));
    assign w_wbin_sync  = PTR_W'(gray2bin(afifo_ptr_t'(w_wq_sync)));
    // The extra wrap bit lets a full FIFO (2**ADDR_WIDTH) read as such rather than 0.
    assign w_level_next = w_wbin_sync - w_bin_next;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_bin    <= '0;
            r_gray   <= '0;
            r_empty  <= 1'b1;
            r_aempty <= 1'b1;
            r_level  <= '0;
            r_uf     <= 1'b0;
        end else begin
            r_bin    <= w_bin_next;
            r_gray   <= w_gray_next;
            // Comparing against the post-read pointer blocks a second read of the last entry.
            r_empty  <= (w_gray_next == w_wq_sync);
            r_aempty <= (w_level_next <= AE_T);
            r_level  <= w_level_next;
            r_uf     <= rinc & r_empty;
        end
    end

    assign ren           = w_racc;
    assign raddr         = r_bin[ADDR_WIDTH-1:0];
    assign rptr          = r_gray;
    assign rempty        = r_empty;
    assign ralmost_empty = r_aempty;
    assign rlevel        = r_level;
    assign runderflow    = r_uf;

endmodule

// File: tb/tb_afifo_rd_ctrl.sv
// Scoreboard bench for afifo_rd_ctrl using an occupancy-count reference model.
module tb_afifo_rd_ctrl;

    localparam int AW  = 4;
    localparam int PW  = AW + 1;
    localparam int AE  = 2;
    localparam int SS  = 2;
    localparam int MOD = 1 << PW;
    localparam int DEP = 1 << AW;

    logic          rclk = 1'b0;
    logic          rrst_n = 1'b0;
    logic          rinc = 1'b1;
    logic [PW-1:0] wptr = '0;
    logic [PW-1:0] rptr;
    logic [AW-1:0] raddr;
    logic          ren;
    logic          rempty;
    logic          ralmost_empty;
    logic [PW-1:0] rlevel;
    logic          runderflow;

    afifo_rd_ctrl #(
        .ADDR_WIDTH  (AW),
        .AE_THRESH   (AE),
        .SYNC_STAGES (SS)
    ) dut (
        .rclk          (rclk),
        .rrst_n        (rrst_n),
        .rinc          (rinc),
        .wptr          (wptr),
        .rptr          (rptr),
        .raddr         (raddr),
        .ren           (ren),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty),
        .rlevel        (rlevel),
        .runderflow    (runderflow)
    );

    always #5 rclk = ~rclk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int empty;
        int aempty;
        int level;
        int uf;
        int rptr;
        int ren;
        int raddr;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    // Reference model: counts of entries written/read and what the reader can see.
    int m_rcnt, m_wbin, m_level, m_empty, m_aempty, m_uf, m_rinc;
    int m_seen [SS];

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function void m_reset();
        m_rcnt = 0; m_wbin = 0; m_level = 0; m_empty = 1; m_aempty = 1;
        m_uf = 0; m_rinc = 0;
        for (int i = 0; i < SS; i++) m_seen[i] = 0;
    endfunction

    function void m_edge();
        int acc;
        int visible;
        acc      = (m_rinc != 0 && m_empty == 0) ? 1 : 0;
        m_uf     = (m_rinc != 0 && m_empty != 0) ? 1 : 0;
        m_rcnt   = (m_rcnt + acc) % MOD;
        visible  = m_seen[SS-1];
        m_level  = (visible - m_rcnt + MOD) % MOD;
        m_empty  = (m_level == 0) ? 1 : 0;
        m_aempty = (m_level <= AE) ? 1 : 0;
        for (int i = SS - 1; i > 0; i--) m_seen[i] = m_seen[i-1];
        m_seen[0] = m_wbin;
    endfunction

    task automatic step(input int ri, input int wb);
        exp_t e;
        @(posedge rclk);
        m_edge();
        #1;
        m_rinc = ri;
        m_wbin = wb % MOD;
        rinc   = ri[0];
        wptr   = PW'(gray(m_wbin));
        e = '{m_empty, m_aempty, m_level, m_uf, gray(m_rcnt),
              (ri != 0 && m_empty == 0) ? 1 : 0, m_rcnt % DEP};
        q.push_back(e);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rempty"}, int'(rempty), 1);
        chk({tag, "_ralmost_empty"}, int'(ralmost_empty), 1);
        chk({tag, "_rlevel"}, int'(rlevel), 0);
        chk({tag, "_runderflow"}, int'(runderflow), 0);
        chk({tag, "_rptr"}, int'(rptr), 0);
        chk({tag, "_ren"}, int'(ren), 0);
        chk({tag, "_raddr"}, int'(raddr), 0);
    endtask

    always @(negedge rclk) begin
        if (rrst_n && q.size() != 0) begin
            mon_e = q.pop_front();
            chk("rempty", int'(rempty), mon_e.empty);
            chk("ralmost_empty", int'(ralmost_empty), mon_e.aempty);
            chk("rlevel", int'(rlevel), mon_e.level);
            chk("runderflow", int'(runderflow), mon_e.uf);
            chk("rptr", int'(rptr), mon_e.rptr);
            chk("ren", int'(ren), mon_e.ren);
            chk("raddr", int'(raddr), mon_e.raddr);
        end
    end

    initial begin
        int occ;
        int inc;
        int ri;

        m_reset();
        rrst_n = 1'b0;
        rinc   = 1'b1;
        wptr   = '0;
        repeat (3) begin
            @(negedge rclk);
            chk_reset("reset");
        end
        rinc   = 1'b0;
        rrst_n = 1'b1;

        // Fill through the synchronizer, then cross the almost-empty threshold.
        step(0, 1); step(0, 2);
        repeat (3) step(0, 2);
        repeat (3) step(0, 3);

        // Drain four entries; the fifth request underflows.
        repeat (3) step(0, 4);
        repeat (5) step(1, 4);
        repeat (2) step(0, 4);

        // Reads keep pace with writes across the address wrap.
        for (int wb = 5; wb <= 20; wb++) step(1, wb);
        repeat (4) step(1, 20);
        repeat (2) step(0, 20);

        // Full depth with the wrap bit set.
        for (int k = 21; k <= 36; k++) step(0, k);
        repeat (3) step(0, 36);

        // Drain fully, then repeated underflow attempts.
        repeat (20) step(1, 36);
        repeat (3) step(1, 36);
        repeat (2) step(0, 36);

        // Randomized traffic, writer never overfills.
        for (int n = 0; n < 400; n++) begin
            ri  = int'($urandom_range(0, 1));
            occ = (m_wbin - m_rcnt + MOD) % MOD;
            inc = (occ < DEP && $urandom_range(0, 2) != 0) ? 1 : 0;
            step(ri, m_wbin + inc);
        end

        // Build up a backlog and reset asynchronously mid-drain.
        for (int k = 1; k <= 8; k++) begin
            occ = (m_wbin - m_rcnt + MOD) % MOD;
            step(0, (occ < DEP) ? m_wbin + 1 : m_wbin);
        end
        repeat (3) step(0, m_wbin);
        repeat (3) step(1, m_wbin);
        @(negedge rclk);
        #2;
        rrst_n = 1'b0;
        wptr   = '0;
        #1;
        chk_reset("async_reset");
        q.delete();
        m_reset();
        @(negedge rclk);
        chk_reset("held_reset");
        @(negedge rclk);
        rinc   = 1'b0;
        rrst_n = 1'b1;

        // Restart: fill to full depth from rbin=0, then read from address 0.
        for (int k = 1; k <= 16; k++) step(0, k);
        repeat (3) step(0, 16);
        repeat (4) step(1, 16);
        repeat (2) step(0, 16);

        @(negedge rclk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
